// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and state encoding for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord   = '0;
  localparam logic               RstEnable  = 1'b1;
  localparam logic               ChipEnable = 1'b1;
  localparam logic               Stop       = 1'b1;
  localparam logic               NoStop     = 1'b0;

  // Fetch sequencing: DRAIN waits out a request that a flush made worthless.
  typedef enum logic [1:0] {
    IfIdle  = 2'd0,
    IfWait  = 2'd1,
    IfDone  = 2'd2,
    IfDrain = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: issues pc on a req/ack bus and presents the returned word to IF/ID.
// Latency: 3 cycles per instruction with zero-wait memory, plus one per memory wait cycle.
// Backpressure: holds the captured word while stall[1]; raises stallreq_o while a fetch is outstanding.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc,
  input  logic                   ce,
  input  logic [5:0]             stall,
  input  logic                   flush,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [InstBus-1:0]     mem_rdata_i,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  output logic                   if_valid_o,
  output logic                   stallreq_o
);

  if_state_e              state_q, state_d;
  logic                   req_q, req_d;
  logic [InstAddrBus-1:0] addr_q, addr_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic                   valid_q, valid_d;

  // Only the IF/ID hold bit matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  // State and capture registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IfIdle;
      req_q   <= 1'b0;
      addr_q  <= ZeroWord;
      pc_q    <= ZeroWord;
      inst_q  <= ZeroWord;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; flush takes priority, but a live request must still be drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IfIdle:  if (ce == ChipEnable && !flush) state_d = IfWait;
      IfWait: begin
        if (flush)          state_d = mem_ack_i ? IfIdle : IfDrain;
        else if (mem_ack_i) state_d = IfDone;
      end
      IfDone:  if (flush || stall[1] == NoStop) state_d = IfIdle;
      IfDrain: if (mem_ack_i) state_d = IfIdle;
      default: state_d = IfIdle;
    endcase
  end

  // Bus request and capture datapath; a flush always empties the IF/ID-facing word.
  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    unique case (state_q)
      IfIdle: begin
        if (ce == ChipEnable && !flush) begin
          req_d  = 1'b1;
          addr_d = pc;
        end
      end
      IfWait: begin
        if (mem_ack_i) begin
          req_d = 1'b0;
          if (!flush) begin
            inst_d  = mem_rdata_i;
            pc_d    = addr_q;
            valid_d = 1'b1;
          end
        end
      end
      IfDone: begin
        if (!flush && stall[1] == NoStop) valid_d = 1'b0;
      end
      IfDrain: begin
        if (mem_ack_i) req_d = 1'b0;
      end
      default: req_d = 1'b0;
    endcase
    if (flush) begin
      valid_d = 1'b0;
      inst_d  = ZeroWord;
    end
  end

  // Stall request is combinational so the PC generator sees it in the same cycle.
  always_comb begin
    stallreq_o = 1'b0;
    unique case (state_q)
      IfIdle:  stallreq_o = (ce == ChipEnable) && !flush;
      IfWait:  stallreq_o = 1'b1;
      IfDone:  stallreq_o = 1'b0;
      IfDrain: stallreq_o = 1'b1;
      default: stallreq_o = 1'b0;
    endcase
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;
  assign if_pc_o    = pc_q;
  assign if_inst_o  = inst_q;
  assign if_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model (outstanding / doomed / holding flags) predicts every output each cycle.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        stallreq_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic        m_out;      // a bus request is outstanding
  logic        m_doomed;   // outstanding request was flushed, its data must be dropped
  logic        m_hold;     // a fetched instruction waits for IF/ID
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ce         (ce),
    .stall      (stall),
    .flush      (flush),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .if_pc_o    (if_pc_o),
    .if_inst_o  (if_inst_o),
    .if_valid_o (if_valid_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against model, clock, advance model.
  task automatic step(input logic r, input logic c, input logic f, input logic s1,
                      input logic a, input logic [31:0] p, input logic [31:0] d);
    logic exp_stallreq;
    @(negedge clk);
    rst = r; ce = c; flush = f; mem_ack_i = a; pc = p; mem_rdata_i = d;
    stall = {4'b0000, s1, 1'b0};
    #1;
    chk("mem_req",  {31'b0, mem_req_o},  {31'b0, m_out});
    chk("mem_addr", mem_addr_o, m_addr);
    chk("if_pc",    if_pc_o,    m_pc);
    chk("if_inst",  if_inst_o,  m_inst);
    chk("if_valid", {31'b0, if_valid_o}, {31'b0, m_hold});
    if (!r) begin
      exp_stallreq = m_out ? 1'b1 : (m_hold ? 1'b0 : (c & ~f));
      chk("stallreq", {31'b0, stallreq_o}, {31'b0, exp_stallreq});
    end
    @(posedge clk);
    if (r) begin
      m_out = 0; m_doomed = 0; m_hold = 0;
      m_addr = 0; m_pc = 0; m_inst = 0;
    end else begin
      if (m_out) begin
        if (a) begin
          m_out = 0;
          if (!m_doomed && !f) begin
            m_hold = 1; m_inst = d; m_pc = m_addr;
          end
          m_doomed = 0;
        end else if (f) begin
          m_doomed = 1;
        end
      end else if (m_hold) begin
        if (f || !s1) m_hold = 0;
      end else if (c && !f) begin
        m_out = 1; m_addr = p;
      end
      if (f) begin
        m_hold = 0; m_inst = 0;
      end
    end
    #1;
  endtask

  int          wait_cnt;
  logic        was_out;
  logic        r_r, r_c, r_f, r_s, r_a;
  logic [31:0] r_p;

  initial begin
    rst = 1; ce = 0; flush = 0; mem_ack_i = 0; pc = 0; mem_rdata_i = 0; stall = 0;
    m_out = 0; m_doomed = 0; m_hold = 0; m_addr = 0; m_pc = 0; m_inst = 0;

    // Reset then enable, zero-wait memory
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_req",   {31'b0, mem_req_o}, 32'd0);
    chk("rst_addr",  mem_addr_o, 32'h0);
    chk("rst_inst",  if_inst_o,  32'h0);
    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    step(0, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("z_req",      {31'b0, mem_req_o}, 32'd1);
    chk("z_addr",     mem_addr_o, 32'h0);
    chk("z_stallreq", {31'b0, stallreq_o}, 32'd1);
    step(0, 1, 0, 0, 1, 32'h0, 32'h34011100);
    chk("z_inst",     if_inst_o, 32'h34011100);
    chk("z_pc",       if_pc_o,   32'h0);
    chk("z_valid",    {31'b0, if_valid_o}, 32'd1);
    chk("z_req_lo",   {31'b0, mem_req_o}, 32'd0);
    chk("z_done_stallreq", {31'b0, stallreq_o}, 32'd0);
    step(0, 1, 0, 0, 0, 32'h4, 32'h0);
    step(0, 1, 0, 0, 0, 32'h4, 32'h0);
    chk("z_next_addr", mem_addr_o, 32'h4);
    step(0, 1, 0, 0, 1, 32'h4, 32'h00000001);
    step(0, 1, 0, 0, 0, 32'h8, 32'h0);

    // Wait states: ack after 3 extra cycles at 0x100
    step(0, 1, 0, 0, 0, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 32'h104, 32'h0);
      chk("w_addr", mem_addr_o, 32'h100);
      chk("w_req",  {31'b0, mem_req_o}, 32'd1);
    end
    step(0, 1, 0, 0, 1, 32'h104, 32'h11112222);
    chk("w_inst", if_inst_o, 32'h11112222);
    chk("w_pc",   if_pc_o,   32'h100);
    step(0, 1, 0, 0, 0, 32'h104, 32'h0);

    // Downstream stall while holding 0x8C220004 from PC 0x8
    step(0, 1, 0, 0, 0, 32'h8, 32'h0);
    step(0, 1, 0, 0, 1, 32'h8, 32'h8C220004);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 1, 0, 32'hC, 32'h0);
      chk("s_valid", {31'b0, if_valid_o}, 32'd1);
      chk("s_inst",  if_inst_o, 32'h8C220004);
      chk("s_req",   {31'b0, mem_req_o}, 32'd0);
    end
    step(0, 1, 0, 0, 0, 32'hC, 32'h0);
    chk("s_released", {31'b0, if_valid_o}, 32'd0);

    // Flush during WAIT with no ack, then late ack of 0xDEADBEEF
    step(0, 1, 0, 0, 0, 32'h20, 32'h0);
    step(0, 1, 1, 0, 0, 32'h20, 32'h0);
    chk("d_req",      {31'b0, mem_req_o}, 32'd1);
    chk("d_addr",     mem_addr_o, 32'h20);
    chk("d_stallreq", {31'b0, stallreq_o}, 32'd1);
    step(0, 1, 0, 0, 0, 32'h20, 32'h0);
    step(0, 1, 0, 0, 1, 32'h20, 32'hDEADBEEF);
    chk("d_valid", {31'b0, if_valid_o}, 32'd0);
    chk("d_inst",  if_inst_o, 32'h0);
    chk("d_req_lo", {31'b0, mem_req_o}, 32'd0);
    step(0, 1, 0, 0, 0, 32'h20, 32'h0);
    chk("d_new_addr", mem_addr_o, 32'h20);

    // Flush coincident with ack
    step(0, 1, 1, 0, 1, 32'h40, 32'hCAFEF00D);
    chk("c_req",   {31'b0, mem_req_o}, 32'd0);
    chk("c_valid", {31'b0, if_valid_o}, 32'd0);
    chk("c_inst",  if_inst_o, 32'h0);

    // Reset in the middle of a fetch
    step(0, 1, 0, 0, 0, 32'h80, 32'h0);
    step(1, 1, 0, 0, 0, 32'h80, 32'h0);
    chk("r_req",  {31'b0, mem_req_o}, 32'd0);
    chk("r_addr", mem_addr_o, 32'h0);

    // ce held low: no request, no stall request
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, i[0], 32'h200, 32'h0);
      chk("ce_req",      {31'b0, mem_req_o}, 32'd0);
      chk("ce_stallreq", {31'b0, stallreq_o}, 32'd0);
    end

    // Randomized traffic with a variable-latency memory
    wait_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      r_r = ($urandom_range(0, 199) == 0);
      r_f = ($urandom_range(0, 14) == 0);
      r_c = ($urandom_range(0, 3) != 0);
      r_s = ($urandom_range(0, 2) == 0);
      r_p = {$urandom_range(0, 16'hFFFF), 2'b00};
      if (m_out) r_a = (wait_cnt == 0);
      else       r_a = ($urandom_range(0, 7) == 0);
      was_out = m_out;
      step(r_r, r_c, r_f, r_s, r_a, r_p, $urandom);
      if (m_out && !was_out)  wait_cnt = $urandom_range(0, 3);
      else if (m_out && wait_cnt > 0) wait_cnt--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
